// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-period helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser with a parameterised reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: synchroniser, mid-bit sampling FSM and a one-entry
// valid/ready holding register with framing and overrun pulses.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 27000000,
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    serial_rx,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    rx_frame_err,
  output logic                    rx_overrun,
  output logic                    rx_busy
);

  localparam int unsigned CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned TW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned IW  = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [TW-1:0] HALF_M1  = TW'(CPB / 2 - 1);
  localparam logic [TW-1:0] CPB_M1   = TW'(CPB - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_BITS - 1);

  logic                    w_rx_s;
  rx_state_t               r_state,   w_state_nxt;
  logic [TW-1:0]           r_timer,   w_timer_nxt;
  logic [IW-1:0]           r_idx,     w_idx_nxt;
  logic [PAYLOAD_BITS-1:0] r_shift,   w_shift_nxt;
  logic                    w_frame_good;
  logic                    w_frame_bad;

  logic [PAYLOAD_BITS-1:0] r_data;
  logic                    r_valid;
  logic                    r_frame_err;
  logic                    r_overrun;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (serial_rx),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer + TW'(1);
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_frame_good = 1'b0;
    w_frame_bad  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_timer_nxt = '0;
        if (!w_rx_s) w_state_nxt = START;
      end
      START: begin
        if (r_timer == HALF_M1) begin
          w_timer_nxt = '0;
          w_idx_nxt   = '0;
          w_state_nxt = w_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_timer == CPB_M1) begin
          w_timer_nxt = '0;
          // LSB arrives first, so shifting in at the MSB leaves it at bit 0
          w_shift_nxt = {w_rx_s, r_shift[PAYLOAD_BITS-1:1]};
          if (r_idx == LAST_IDX) w_state_nxt = STOP;
          else                   w_idx_nxt   = r_idx + IW'(1);
        end
      end
      STOP: begin
        if (r_timer == CPB_M1) begin
          w_timer_nxt = '0;
          if (w_rx_s) begin
            w_frame_good = 1'b1;
            w_state_nxt  = IDLE;
          end else begin
            w_frame_bad  = 1'b1;
            w_state_nxt  = BREAK;
          end
        end
      end
      BREAK: begin
        w_timer_nxt = '0;
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: begin
        w_timer_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // A slot freed by this cycle's handshake may be refilled in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      r_overrun   <= 1'b0;
      if (w_frame_good) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_frame_err = r_frame_err;
  assign rx_overrun   = r_overrun;
  assign rx_busy      = (r_state != IDLE);

endmodule
